div_sequencer: RTL

//  Iterative restoring divider controller for the ALU DIV op. Sequences the shared
//  32-bit Subtract unit one trial subtraction per cycle (no borrow-out from the unit;

---
 rtl/div_sequencer_if.sv | 30 +++
 rtl/div_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Handshake and datapath bundle between the control unit, the shared Subtract
// unit and the div_sequencer restoring-divider controller.
interface div_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  sign_mode;
    logic [DATA_WIDTH-1:0] sub_a;
    logic [DATA_WIDTH-1:0] sub_b;
    logic [DATA_WIDTH-1:0] sub_result;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    // Requester side: control unit plus the shared Subtract unit result.
    modport master (
        output start, dividend, divisor, sign_mode, sub_result,
        input  sub_a, sub_b, busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor, sign_mode, sub_result,
        output sub_a, sub_b, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider controller driving a shared Subtract unit, one
// trial subtraction per cycle. Define DIV_SIGNED_EN to honour sign_mode.
module div_sequencer #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  ZERO_QUOT  = '1
) (
    input logic            clock,
    input logic            clear,
    div_sequencer_if.slave bus
);
    localparam int unsigned CW  = $clog2(DATA_WIDTH);
    localparam int unsigned MSB = DATA_WIDTH - 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [DATA_WIDTH-1:0] rem_r, quo_r, dsr_r;
    logic [DATA_WIDTH-1:0] quotient_r, remainder_r;
    logic                  dbz_r;
    logic [CW-1:0]         count;

    logic [DATA_WIDTH-1:0] mag_a, mag_b, fix_q, fix_r;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  carry, borrow, take;
    logic                  divisor_zero, last_iter;

    logic                  busy, done;
    logic [DATA_WIDTH-1:0] sub_a, sub_b;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
        return ~x + DATA_WIDTH'(1);
    endfunction

    assign divisor_zero = (op_b == '0);
    assign last_iter    = (count == CW'(DATA_WIDTH - 1));

    // The unit has no borrow-out; recover it from the operand and result MSBs.
    // A bit carried out of R means the shifted value exceeds D, so always subtract.
    assign shifted = {rem_r[MSB-1:0], quo_r[MSB]};
    assign carry   = rem_r[MSB];
    assign borrow  = (~sub_a[MSB] & sub_b[MSB]) |
                     (~(sub_a[MSB] ^ sub_b[MSB]) & bus.sub_result[MSB]);
    assign take    = carry | ~borrow;

`ifdef DIV_SIGNED_EN
    logic op_signed;

    always_ff @(posedge clock) begin
        if (clear) begin
            op_signed <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            op_signed <= bus.sign_mode;
        end
    end

    assign mag_a = (op_signed && op_a[MSB]) ? negate(op_a) : op_a;
    assign mag_b = (op_signed && op_b[MSB]) ? negate(op_b) : op_b;
    assign fix_q = (op_signed && (op_a[MSB] ^ op_b[MSB])) ? negate(quo_r) : quo_r;
    assign fix_r = (op_signed && op_a[MSB]) ? negate(rem_r) : rem_r;
`else
    logic sign_mode_unused;

    assign sign_mode_unused = bus.sign_mode;
    assign mag_a = op_a;
    assign mag_b = op_b;
    assign fix_q = quo_r;
    assign fix_r = rem_r;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        sub_a      = '0;
        sub_b      = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = PREP;
                end
            end
            PREP: begin
                busy       = 1'b1;
                state_next = divisor_zero ? DONE : ITER;
            end
            ITER: begin
                busy  = 1'b1;
                sub_a = shifted;
                sub_b = dsr_r;
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            op_a        <= '0;
            op_b        <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dsr_r       <= '0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a <= bus.dividend;
                        op_b <= bus.divisor;
                    end
                end
                PREP: begin
                    if (divisor_zero) begin
                        quotient_r  <= ZERO_QUOT;
                        remainder_r <= op_a;
                        dbz_r       <= 1'b1;
                    end else begin
                        rem_r <= '0;
                        quo_r <= mag_a;
                        dsr_r <= mag_b;
                        count <= '0;
                    end
                end
                ITER: begin
                    rem_r <= take ? bus.sub_result : shifted;
                    quo_r <= {quo_r[MSB-1:0], take};
                    count <= count + CW'(1);
                end
                FIX: begin
                    quotient_r  <= fix_q;
                    remainder_r <= fix_r;
                    dbz_r       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.sub_a       = sub_a;
    assign bus.sub_b       = sub_b;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule
